sip_round_engine: RTL and testbench

Iterative, parametrised SipRound engine. Accepts a SipHash state (v0..v3) plus a runtime round count over a valid/ready handshake. Applies that many SipRounds, folding HALF_PER_CYCLE half-rounds into each clock, and returns the state over a second valid/ready handshake. Serves both compression (c rounds) and finalisation (d rounds) in the SipHash-c-d datapath; WIDTH=32 gives HalfSipHash.

---
 rtl/sip_round_engine_if.sv | 33 +++
 rtl/sip_round_engine.sv | 117 +++++++++++
 tb/tb_sip_round_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sip_round_engine_if.sv
// Handshake bundle for the SipRound engine: job intake, result return,
// abort and status. The master side is the job producer/result consumer.
`timescale 1ns/1ps
interface sip_round_engine_if #(
  parameter int WIDTH  = 64,
  parameter int RCNT_W = 4
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [RCNT_W-1:0] in_rounds;
  logic [WIDTH-1:0]  in_v0;
  logic [WIDTH-1:0]  in_v1;
  logic [WIDTH-1:0]  in_v2;
  logic [WIDTH-1:0]  in_v3;
  logic              out_valid;
  logic              out_ready;
  logic [WIDTH-1:0]  out_v0;
  logic [WIDTH-1:0]  out_v1;
  logic [WIDTH-1:0]  out_v2;
  logic [WIDTH-1:0]  out_v3;
  logic              busy;

  modport master (
    output flush, in_valid, in_rounds, in_v0, in_v1, in_v2, in_v3, out_ready,
    input  in_ready, out_valid, out_v0, out_v1, out_v2, out_v3, busy
  );

  modport slave (
    input  flush, in_valid, in_rounds, in_v0, in_v1, in_v2, in_v3, out_ready,
    output in_ready, out_valid, out_v0, out_v1, out_v2, out_v3, busy
  );
endinterface

// File: rtl/sip_round_engine.sv
// Iterative SipRound engine. Takes a SipHash state and a round count,
// applies HALF_PER_CYCLE half-rounds per clock and hands the state back.
// WIDTH=64 is SipHash, WIDTH=32 is HalfSipHash.
`timescale 1ns/1ps
module sip_round_engine #(
  parameter int WIDTH          = 64,
  parameter int HALF_PER_CYCLE = 1,
  parameter int RCNT_W         = 4
) (
  input  logic clk,
  input  logic rst_n,
  sip_round_engine_if.slave bus
);
  typedef logic [WIDTH-1:0] word_t;
  typedef struct packed {
    word_t v0;
    word_t v1;
    word_t v2;
    word_t v3;
  } state_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_e;

  // Rotation amounts for the two half-round flavours.
  localparam int unsigned A1 = (WIDTH == 32) ? 5  : 13;
  localparam int unsigned A3 = (WIDTH == 32) ? 8  : 16;
  localparam int unsigned B1 = (WIDTH == 32) ? 13 : 17;
  localparam int unsigned B3 = (WIDTH == 32) ? 7  : 21;
  localparam int unsigned RR = WIDTH / 2;
  localparam logic [RCNT_W:0] HSUB = (RCNT_W+1)'(HALF_PER_CYCLE);

  fsm_e            state, state_nxt;
  state_t          st, step;
  logic [RCNT_W:0] rem, rem_dec;
  logic            phase;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WIDTH - n));
  endfunction

  // Half B is half A with the roles of v0 and v2 swapped and different
  // rotation amounts, so one adder/rotate structure serves both.
  function automatic state_t half_round(input state_t s, input logic phase_b);
    state_t r;
    word_t  p, q;
    p    = (phase_b ? s.v2 : s.v0) + s.v1;
    q    = (phase_b ? s.v0 : s.v2) + s.v3;
    r.v1 = (phase_b ? rotl(s.v1, B1) : rotl(s.v1, A1)) ^ p;
    r.v3 = (phase_b ? rotl(s.v3, B3) : rotl(s.v3, A3)) ^ q;
    p    = rotl(p, RR);
    r.v0 = phase_b ? q : p;
    r.v2 = phase_b ? p : q;
    return r;
  endfunction

  assign rem_dec = rem - HSUB;

  // Combinational work done in one RUN cycle: one half-round chosen by
  // phase, or a full A-then-B round when two halves are unrolled.
  always_comb begin
    step = st;
    if (HALF_PER_CYCLE == 2) step = half_round(half_round(st, 1'b0), 1'b1);
    else                     step = half_round(st, phase);
  end

  // Next-state decode; flush overrides everything including a new job.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (bus.in_valid) state_nxt = (bus.in_rounds != '0) ? RUN : DONE;
      RUN:  if (rem_dec == '0) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.flush) state_nxt = IDLE;
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Working state, remaining half-round count and A/B phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= '0;
      rem   <= '0;
      phase <= 1'b0;
    end else if (bus.flush) begin
      st    <= '0;
      rem   <= '0;
      phase <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid) begin
          st    <= '{bus.in_v0, bus.in_v1, bus.in_v2, bus.in_v3};
          rem   <= {bus.in_rounds, 1'b0};
          phase <= 1'b0;
        end
        RUN: begin
          st    <= step;
          rem   <= rem_dec;
          phase <= (HALF_PER_CYCLE == 1) ? ~phase : 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.out_v0    = st.v0;
  assign bus.out_v1    = st.v1;
  assign bus.out_v2    = st.v2;
  assign bus.out_v3    = st.v3;
endmodule

// File: tb/tb_sip_round_engine.sv
// Bench for sip_round_engine: four engines (64/32-bit lanes, one or two
// half-rounds per clock) share one stimulus stream and are compared with a
// plain software SipRound model and with published reference vectors.
`timescale 1ns/1ps
module tb_sip_round_engine;
  typedef logic [3:0][63:0] st_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       flush, in_valid, out_ready;
  logic [3:0] in_rounds;
  st_t        in_v;

  logic [63:0] ov [4][4];
  logic        ovld [4];
  logic        ird  [4];
  logic        bsy  [4];

  int vectors = 0;
  int miscompares = 0;
  int lat [4];

  always #5 clk = ~clk;

  sip_round_engine_if #(.WIDTH(64), .RCNT_W(4)) if_a ();
  sip_round_engine_if #(.WIDTH(64), .RCNT_W(4)) if_b ();
  sip_round_engine_if #(.WIDTH(32), .RCNT_W(4)) if_c ();
  sip_round_engine_if #(.WIDTH(32), .RCNT_W(4)) if_d ();

  sip_round_engine #(.WIDTH(64), .HALF_PER_CYCLE(1), .RCNT_W(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  sip_round_engine #(.WIDTH(64), .HALF_PER_CYCLE(2), .RCNT_W(4)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  sip_round_engine #(.WIDTH(32), .HALF_PER_CYCLE(1), .RCNT_W(4)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));
  sip_round_engine #(.WIDTH(32), .HALF_PER_CYCLE(2), .RCNT_W(4)) dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d.slave));

  assign if_a.flush = flush;  assign if_a.in_valid = in_valid;  assign if_a.in_rounds = in_rounds;
  assign if_a.out_ready = out_ready;
  assign if_a.in_v0 = in_v[0];  assign if_a.in_v1 = in_v[1];  assign if_a.in_v2 = in_v[2];  assign if_a.in_v3 = in_v[3];
  assign if_b.flush = flush;  assign if_b.in_valid = in_valid;  assign if_b.in_rounds = in_rounds;
  assign if_b.out_ready = out_ready;
  assign if_b.in_v0 = in_v[0];  assign if_b.in_v1 = in_v[1];  assign if_b.in_v2 = in_v[2];  assign if_b.in_v3 = in_v[3];
  assign if_c.flush = flush;  assign if_c.in_valid = in_valid;  assign if_c.in_rounds = in_rounds;
  assign if_c.out_ready = out_ready;
  assign if_c.in_v0 = in_v[0][31:0];  assign if_c.in_v1 = in_v[1][31:0];
  assign if_c.in_v2 = in_v[2][31:0];  assign if_c.in_v3 = in_v[3][31:0];
  assign if_d.flush = flush;  assign if_d.in_valid = in_valid;  assign if_d.in_rounds = in_rounds;
  assign if_d.out_ready = out_ready;
  assign if_d.in_v0 = in_v[0][31:0];  assign if_d.in_v1 = in_v[1][31:0];
  assign if_d.in_v2 = in_v[2][31:0];  assign if_d.in_v3 = in_v[3][31:0];

  assign ov[0][0] = if_a.out_v0;  assign ov[0][1] = if_a.out_v1;  assign ov[0][2] = if_a.out_v2;  assign ov[0][3] = if_a.out_v3;
  assign ov[1][0] = if_b.out_v0;  assign ov[1][1] = if_b.out_v1;  assign ov[1][2] = if_b.out_v2;  assign ov[1][3] = if_b.out_v3;
  assign ov[2][0] = {32'h0, if_c.out_v0};  assign ov[2][1] = {32'h0, if_c.out_v1};
  assign ov[2][2] = {32'h0, if_c.out_v2};  assign ov[2][3] = {32'h0, if_c.out_v3};
  assign ov[3][0] = {32'h0, if_d.out_v0};  assign ov[3][1] = {32'h0, if_d.out_v1};
  assign ov[3][2] = {32'h0, if_d.out_v2};  assign ov[3][3] = {32'h0, if_d.out_v3};
  assign ovld[0] = if_a.out_valid;  assign ovld[1] = if_b.out_valid;
  assign ovld[2] = if_c.out_valid;  assign ovld[3] = if_d.out_valid;
  assign ird[0] = if_a.in_ready;  assign ird[1] = if_b.in_ready;
  assign ird[2] = if_c.in_ready;  assign ird[3] = if_d.in_ready;
  assign bsy[0] = if_a.busy;  assign bsy[1] = if_b.busy;  assign bsy[2] = if_c.busy;  assign bsy[3] = if_d.busy;

  function automatic int w_of(input int i);
    return (i < 2) ? 64 : 32;
  endfunction

  function automatic int h_of(input int i);
    return (i % 2 == 0) ? 1 : 2;
  endfunction

  function automatic st_t mk(input logic [63:0] a, input logic [63:0] b, input logic [63:0] c, input logic [63:0] d);
    st_t s;
    s[0] = a; s[1] = b; s[2] = c; s[3] = d;
    return s;
  endfunction

  function automatic logic [63:0] rl(input logic [63:0] x, input int n, input int w);
    logic [63:0] m, y;
    m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    y = x & m;
    return ((y << n) | (y >> (w - n))) & m;
  endfunction

  // Straight-line SipRound: half A then half B, repeated r times.
  function automatic st_t sip_model(input st_t s, input int r, input int w);
    logic [63:0] m, v0, v1, v2, v3;
    int a1, a3, b1, b3, rr;
    m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    a1 = (w == 64) ? 13 : 5;   a3 = (w == 64) ? 16 : 8;
    b1 = (w == 64) ? 17 : 13;  b3 = (w == 64) ? 21 : 7;
    rr = w / 2;
    v0 = s[0] & m; v1 = s[1] & m; v2 = s[2] & m; v3 = s[3] & m;
    for (int k = 0; k < r; k++) begin
      v0 = (v0 + v1) & m; v1 = rl(v1, a1, w) ^ v0; v0 = rl(v0, rr, w);
      v2 = (v2 + v3) & m; v3 = rl(v3, a3, w) ^ v2;
      v2 = (v2 + v1) & m; v1 = rl(v1, b1, w) ^ v2; v2 = rl(v2, rr, w);
      v0 = (v0 + v3) & m; v3 = rl(v3, b3, w) ^ v0;
    end
    return mk(v0, v1, v2, v3);
  endfunction

  function automatic st_t rand_state();
    st_t s;
    for (int j = 0; j < 4; j++) s[j] = {$urandom(), $urandom()};
    return s;
  endfunction

  // Offer one job (called #1 after an edge with all engines idle), then
  // record for each engine how many edges after acceptance out_valid rose.
  task automatic run_job(input int r, input st_t v);
    bit all_done;
    in_rounds = 4'(r);
    in_v      = v;
    in_valid  = 1'b1;
    @(posedge clk); #1;
    in_valid  = 1'b0;
    in_v      = rand_state();
    in_rounds = 4'($urandom_range(0, 15));
    for (int i = 0; i < 4; i++) lat[i] = -1;
    for (int k = 0; k <= 40; k++) begin
      all_done = 1'b1;
      for (int i = 0; i < 4; i++) begin
        if (lat[i] < 0 && ovld[i] === 1'b1) lat[i] = k;
        if (lat[i] < 0) all_done = 1'b0;
      end
      if (all_done) break;
      @(posedge clk); #1;
    end
  endtask

  task automatic release_job();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ird[i] !== 1'b1 || ovld[i] !== 1'b0 || bsy[i] !== 1'b0 ||
          ov[i][0] !== 64'h0 || ov[i][1] !== 64'h0 || ov[i][2] !== 64'h0 || ov[i][3] !== 64'h0) begin
        miscompares++;
        $display("FAIL reset_state inst%0d got rdy=%b vld=%b busy=%b v0=%h required rdy=1 vld=0 busy=0 v=0",
                 i, ird[i], ovld[i], bsy[i], ov[i][0]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ird[i] !== 1'b1 || bsy[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL idle_after_reset inst%0d got rdy=%b busy=%b required rdy=1 busy=0", i, ird[i], bsy[i]);
      end
    end
  endtask

  task automatic test_directed_vectors();
    st_t tv [4];
    st_t te [4];
    int  tr [4];
    st_t exp;
    tr = '{1, 1, 0, 15};
    tv[0] = mk(64'h0, 64'h8000000000000000, 64'h0, 64'h0);
    te[0] = mk(64'h0000000080000000, 64'h8000000020011000, 64'h0000100080000000, 64'h0000000080000000);
    tv[1] = mk(64'h0, 64'h1, 64'h0, 64'h0);
    te[1] = mk(64'h0000000100000000, 64'h0000000040022001, 64'h0000200100000000, 64'h0000000100000000);
    tv[2] = mk(64'h1, 64'h2, 64'h3, 64'h4);
    te[2] = mk(64'h1, 64'h2, 64'h3, 64'h4);
    tv[3] = mk(64'h0, 64'h0, 64'h0, 64'h0);
    te[3] = mk(64'h0, 64'h0, 64'h0, 64'h0);
    for (int t = 0; t < 4; t++) begin
      run_job(tr[t], tv[t]);
      for (int i = 0; i < 4; i++) begin
        exp = (i < 2) ? te[t] : sip_model(tv[t], tr[t], 32);
        for (int j = 0; j < 4; j++) begin
          vectors++;
          if (ov[i][j] !== exp[j]) begin
            miscompares++;
            $display("FAIL directed%0d inst%0d v%0d got %h required %h", t, i, j, ov[i][j], exp[j]);
          end
        end
        vectors++;
        if (lat[i] !== 2 * tr[t] / h_of(i)) begin
          miscompares++;
          $display("FAIL directed%0d_latency inst%0d got %0d required %0d", t, i, lat[i], 2 * tr[t] / h_of(i));
        end
      end
      release_job();
    end
  endtask

  task automatic test_backpressure();
    st_t v, exp;
    v = rand_state();
    run_job(2, v);
    repeat (10) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        exp = sip_model(v, 2, w_of(i));
        vectors++;
        if (ovld[i] !== 1'b1 || ird[i] !== 1'b0 || bsy[i] !== 1'b1 ||
            ov[i][0] !== exp[0] || ov[i][1] !== exp[1] || ov[i][2] !== exp[2] || ov[i][3] !== exp[3]) begin
          miscompares++;
          $display("FAIL backpressure_hold inst%0d got vld=%b rdy=%b v0=%h v3=%h required vld=1 rdy=0 v0=%h v3=%h",
                   i, ovld[i], ird[i], ov[i][0], ov[i][3], exp[0], exp[3]);
        end
      end
    end
    release_job();
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ird[i] !== 1'b1 || ovld[i] !== 1'b0 || bsy[i] !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure_release inst%0d got rdy=%b vld=%b busy=%b required 1 0 0", i, ird[i], ovld[i], bsy[i]);
      end
    end
  endtask

  task automatic test_flush();
    st_t exp, basic;
    basic = mk(64'h0000000100000000, 64'h0000000040022001, 64'h0000200100000000, 64'h0000000100000000);
    in_rounds = 4'd4; in_v = rand_state(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ird[i] !== 1'b1 || ovld[i] !== 1'b0 || bsy[i] !== 1'b0 || ov[i][1] !== 64'h0) begin
        miscompares++;
        $display("FAIL flush_run inst%0d got rdy=%b vld=%b busy=%b v1=%h required 1 0 0 0", i, ird[i], ovld[i], bsy[i], ov[i][1]);
      end
    end
    repeat (6) begin
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (ovld[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_no_output inst%0d got vld=%b required 0", i, ovld[i]);
        end
      end
    end
    run_job(1, mk(64'h0, 64'h1, 64'h0, 64'h0));
    for (int i = 0; i < 4; i++) begin
      exp = (i < 2) ? basic : sip_model(mk(64'h0, 64'h1, 64'h0, 64'h0), 1, 32);
      for (int j = 0; j < 4; j++) begin
        vectors++;
        if (ov[i][j] !== exp[j]) begin
          miscompares++;
          $display("FAIL after_flush inst%0d v%0d got %h required %h", i, j, ov[i][j], exp[j]);
        end
      end
    end
    release_job();
    flush = 1'b1; in_valid = 1'b1; in_rounds = 4'd3;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (ird[i] !== 1'b1 || bsy[i] !== 1'b0) begin
          miscompares++;
          $display("FAIL flush_beats_valid inst%0d got rdy=%b busy=%b required 1 0", i, ird[i], bsy[i]);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midrun();
    st_t v;
    in_rounds = 4'd8; in_v = rand_state(); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ird[i] !== 1'b1 || ovld[i] !== 1'b0 || bsy[i] !== 1'b0 ||
          ov[i][0] !== 64'h0 || ov[i][1] !== 64'h0 || ov[i][2] !== 64'h0 || ov[i][3] !== 64'h0) begin
        miscompares++;
        $display("FAIL async_reset inst%0d got rdy=%b vld=%b busy=%b v0=%h required 1 0 0 0", i, ird[i], ovld[i], bsy[i], ov[i][0]);
      end
    end
    v = rand_state();
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b1; in_rounds = 4'd0; in_v = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (ovld[i] !== 1'b1 || ov[i][0] !== sip_model(v, 0, w_of(i))[0] || ov[i][3] !== sip_model(v, 0, w_of(i))[3]) begin
        miscompares++;
        $display("FAIL accept_after_reset inst%0d got vld=%b v0=%h required vld=1 v0=%h", i, ovld[i], ov[i][0], sip_model(v, 0, w_of(i))[0]);
      end
    end
    release_job();
  endtask

  task automatic test_random();
    st_t v, exp;
    int  r;
    for (int n = 0; n < 24; n++) begin
      v = rand_state();
      r = $urandom_range(0, 15);
      run_job(r, v);
      for (int i = 0; i < 4; i++) begin
        exp = sip_model(v, r, w_of(i));
        for (int j = 0; j < 4; j++) begin
          vectors++;
          if (ov[i][j] !== exp[j]) begin
            miscompares++;
            $display("FAIL random%0d r=%0d inst%0d v%0d got %h required %h", n, r, i, j, ov[i][j], exp[j]);
          end
        end
        vectors++;
        if (lat[i] !== 2 * r / h_of(i)) begin
          miscompares++;
          $display("FAIL random%0d_latency inst%0d got %0d required %0d", n, i, lat[i], 2 * r / h_of(i));
        end
      end
      release_job();
    end
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_rounds = 4'd0; in_v = '0;
    test_reset();
    test_directed_vectors();
    test_backpressure();
    test_flush();
    test_reset_midrun();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
